// File: rtl/nes_vga_pkg.sv
// rtl/nes_vga_pkg.sv - shared constants and NES palette for the VGA line-doubling scaler
package nes_vga_pkg;

  localparam int         NES_WIDTH  = 256;
  localparam logic [9:0] H_BORDER   = 10'd64;
  localparam logic [9:0] H_TOTAL    = 10'd800;
  localparam logic [9:0] V_TOTAL    = 10'd525;
  localparam logic [9:0] V_VISIBLE  = 10'd480;
  localparam logic [9:0] H_PIX_LAST = H_BORDER + 10'(2 * NES_WIDTH) - 10'd1;

  // 64-entry NES palette, RGB444 packed as {r, g, b}
  localparam logic [11:0] NES_PALETTE [64] = '{
    12'h666, 12'h02A, 12'h10B, 12'h30A, 12'h507, 12'h603, 12'h600, 12'h410,
    12'h220, 12'h030, 12'h040, 12'h032, 12'h034, 12'h000, 12'h000, 12'h000,
    12'hAAA, 12'h05D, 12'h33F, 12'h72E, 12'hA1A, 12'hC16, 12'hC20, 12'h940,
    12'h660, 12'h080, 12'h090, 12'h085, 12'h078, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'hA7F, 12'hE6F, 12'hF6B, 12'hF74, 12'hD92,
    12'hAB1, 12'h6C2, 12'h3D5, 12'h3DA, 12'h3CD, 12'h444, 12'h000, 12'h000,
    12'hFFF, 12'hBEF, 12'hCCF, 12'hDCF, 12'hFBF, 12'hFBD, 12'hFCB, 12'hFDA,
    12'hEE9, 12'hCE9, 12'hAEB, 12'hAED, 12'hAEF, 12'hAAA, 12'h000, 12'h000
  };

  function automatic logic [11:0] palette_lookup(input logic [5:0] idx);
    return NES_PALETTE[idx];
  endfunction

endpackage

// File: rtl/nes_line_ram.sv
// rtl/nes_line_ram.sv - 512x6 simple dual-port RAM holding both NES line buffers
module nes_line_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [8:0] waddr,
  input  logic [5:0] wdata,
  input  logic [8:0] raddr,
  output logic [5:0] rdata
);

  logic [5:0] mem [512];

  // write port, address is {buffer select, x}
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/nes_vga_scaler.sv
// rtl/nes_vga_scaler.sv - 2x NES-to-VGA scaler, ping-pong line buffers; NES_VGA_SCANLINE_EN dims odd lines
module nes_vga_scaler
  import nes_vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ppu_pix_valid,
  input  logic [5:0] ppu_pix_idx,
  output logic       ppu_ready,
  input  logic       ppu_frame_start,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       blank_in,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       h_sync_out,
  output logic       v_sync_out,
  output logic       underrun
);

  logic [7:0]  wr_x;
  logic        wr_full;
  logic        wr_sel;
  logic        wr_accept;
  logic        wr_en;
  logic        swap_pt;
  logic [7:0]  rd_x;
  logic        border;
  logic [5:0]  ram_q;
  logic        hs_d1, vs_d1, blank_d1, border_d1;
  logic [11:0] pix;
  logic [11:0] rgb_q;

  assign ppu_ready = !wr_full;
  assign wr_accept = ppu_pix_valid && ppu_ready;
  // a frame start discards the pixel offered in the same cycle
  assign wr_en     = wr_accept && !ppu_frame_start;

  // swap after every second VGA line of the visible area and at the end of the frame
  assign swap_pt = (h_cnt == H_TOTAL - 10'd1) &&
                   ((v_cnt == V_TOTAL - 10'd1) || (v_cnt[0] && (v_cnt < V_VISIBLE - 10'd1)));

  assign rd_x   = 8'((h_cnt - H_BORDER) >> 1);
  assign border = (h_cnt < H_BORDER) || (h_cnt > H_PIX_LAST);

  // write pointer, buffer ownership and sticky underrun
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_x     <= 8'd0;
      wr_full  <= 1'b0;
      wr_sel   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (swap_pt) begin
        if (wr_full) begin
          wr_sel  <= ~wr_sel;
          wr_full <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end
      if (ppu_frame_start) begin
        wr_x <= 8'd0;
      end else if (wr_accept) begin
        wr_x <= wr_x + 8'd1;
        if (wr_x == 8'(NES_WIDTH - 1)) wr_full <= 1'b1;
      end
    end
  end

  nes_line_ram u_line_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_sel, wr_x}),
    .wdata (ppu_pix_idx),
    .raddr ({~wr_sel, rd_x}),
    .rdata (ram_q)
  );

`ifdef NES_VGA_SCANLINE_EN
  logic vodd_d1;

  // odd-line flag travels with the read data
  always_ff @(posedge clk) begin
    if (rst) vodd_d1 <= 1'b0;
    else     vodd_d1 <= v_cnt[0];
  end

  // odd VGA lines get every component halved
  always_comb begin
    pix = palette_lookup(ram_q);
    if (vodd_d1) pix = {1'b0, pix[11:9], 1'b0, pix[7:5], 1'b0, pix[3:1]};
  end
`else
  // both lines of a doubled pair are identical
  always_comb begin
    pix = palette_lookup(ram_q);
  end
`endif

  // two-stage delay of sync/blank/border to line up with the palette stage
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_d1      <= 1'b1;
      vs_d1      <= 1'b0;
      blank_d1   <= 1'b1;
      border_d1  <= 1'b1;
      h_sync_out <= 1'b1;
      v_sync_out <= 1'b0;
    end else begin
      hs_d1      <= h_sync_in;
      vs_d1      <= v_sync_in;
      blank_d1   <= blank_in;
      border_d1  <= border;
      h_sync_out <= hs_d1;
      v_sync_out <= vs_d1;
    end
  end

  // registered palette stage, black during blank and border
  always_ff @(posedge clk) begin
    if (rst)                        rgb_q <= 12'h000;
    else if (blank_d1 || border_d1) rgb_q <= 12'h000;
    else                            rgb_q <= pix;
  end

  assign {red, green, blue} = rgb_q;

endmodule

// File: doc/nes_vga_scaler.md
NES_VGA_SCALER -- requirements
Module: nes_vga_scaler

Interface
REQ-001 SHALL have ports in order: clk in 1 pixel clock (25.175 MHz); rst in 1 synchronous active-high reset.
REQ-002 ppu_pix_valid in 1 PPU pixel strobe; ppu_pix_idx in 6 palette index; ppu_ready out 1 write-side ready; ppu_frame_start in 1 one-cycle frame-start pulse.
REQ-003 h_cnt in 10, v_cnt in 10, h_sync_in in 1, v_sync_in in 1, blank_in in 1: outputs of the 640x480 timing generator (800x525 total).
REQ-004 red, green, blue out 4 each; h_sync_out, v_sync_out out 1; underrun out 1 sticky flag.

Function
REQ-005 SHALL hold two 256x6 line buffers (ping-pong): one write buffer (wr_sel), one read buffer (rd_sel = ~wr_sel).
REQ-006 Write: pixel accepted when ppu_pix_valid && ppu_ready; stored at wr_x; wr_x increments; ppu_pix_valid ignored while ppu_ready low.
REQ-007 Acceptance at wr_x==255 SHALL set wr_full, wr_x wraps to 0; ppu_ready = !wr_full.
REQ-008 ppu_frame_start SHALL force wr_x to 0 (partial line discarded); wr_full unchanged; takes priority over a same-cycle write.
REQ-009 Swap point: h_cnt==799 and (v_cnt==524 or (v_cnt odd and v_cnt<479)).
REQ-010 At swap with wr_full==1 (value before this edge): toggle wr_sel, clear wr_full.
REQ-011 At swap with wr_full==0: no toggle, read buffer repeats previous NES line, underrun set to 1.
REQ-012 A line completing on the swap cycle SHALL NOT be swapped until the next swap point.
REQ-013 Each NES line SHALL display on two VGA lines (2x vertical); NES x = (h_cnt-64)>>1 for h_cnt 64..575 (2x horizontal, centred).
REQ-014 h_cnt <64 or >575 in visible region SHALL output border black (RGB 0).
REQ-015 Read pipeline: stage 0 address from h_cnt, stage 1 buffer data, stage 2 registered palette lookup -> RGB; latency exactly 2 clocks.
REQ-016 h_sync_in, v_sync_in, blank_in, border flag SHALL be delayed 2 clocks to align with RGB.
REQ-017 RGB SHALL be 0 whenever delayed blank is high.
REQ-018 underrun SHALL clear only on rst.

Reset
REQ-019 rst SHALL set: RGB 0, h_sync_out 1, v_sync_out 0, wr_x 0, wr_full 0, wr_sel 0, underrun 0, delay pipeline to (h_sync 1, v_sync 0, blank 1).
REQ-020 rst mid-line SHALL discard partial write; buffer RAM contents need not clear.

Configuration
REQ-021 Macro NES_VGA_SCANLINE_EN: when defined, RGB on odd v_cnt lines (v_cnt latched with pipeline) SHALL be each component >>1; when undefined, both lines of a pair identical.

Structure
REQ-022 Package nes_vga_pkg SHALL hold 64-entry 12-bit NES palette table, H_BORDER=64, NES_WIDTH=256, timing totals (800, 525).
REQ-023 One sub-module nes_line_ram: simple dual-port 512x6 RAM (1 write port, 1 registered read port), address {sel, x}.

Verification
REQ-024 Load line of idx 0x21, wait swap, v_cnt=0 -> h_cnt 64,65 yield palette[0x21] on clocks +2,+3; h_cnt 63 -> RGB 0.
REQ-025 Write x=0 idx 0x01, x=1 idx 0x02 -> h_cnt 64,65 show palette[0x01], 66,67 show palette[0x02].
REQ-026 No PPU writes across swap at v_cnt=1, h_cnt=799 -> underrun=1, lines 2,3 repeat lines 0,1 content.
REQ-027 256th write lands at h_cnt=799,v_cnt=1 -> no swap that point, swap at v_cnt=3; ppu_ready low until then.
REQ-028 ppu_frame_start after 100 writes -> next write lands at x=0; h_sync_in low at h_cnt 656 -> h_sync_out low 2 clocks later.
REQ-029 With NES_VGA_SCANLINE_EN, palette 0xFFF on v_cnt=1 -> RGB 0x777; v_cnt=0 -> 0xFFF.
